i2c_codec_responder: RTL and testbench

I2C_CODEC_RESPONDER -- requirements
Module: i2c_codec_responder

---
 rtl/i2c_codec_pkg.sv | 27 ++
 rtl/i2c_sync_edge.sv | 35 +++
 rtl/i2c_codec_responder.sv | 184 ++++++++++++++++++
 tb/tb_i2c_codec_responder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_codec_pkg.sv
// Shared definitions for the I2C codec write responder: FSM states,
// the default codec target address and the address-byte decode helper.
package i2c_codec_pkg;

    // Target address of the codec when its CSB pin is tied low
    localparam logic [6:0] CODEC_DEV_ADDR = 7'h1A;

    // Value of the 3-bit bit counter while the last bit of a byte is shifted
    localparam logic [2:0] LAST_BIT = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_BYTE1,
        ST_ACK1,
        ST_BYTE2,
        ST_ACK2,
        ST_IGNORE
    } state_t;

    // An address byte selects us only for a write (R/W bit low) to our address
    function automatic logic isWriteTo(input logic [7:0] addrByte, input logic [6:0] devAddr);
        return (addrByte[7:1] == devAddr) && !addrByte[0];
    endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Brings one asynchronous bus line into the clk domain and flags its edges.
// Flops reset high so an idle (pulled-up) bus never produces a spurious edge.
module i2c_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_sig,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // Synchroniser chain plus one extra flop holding the previous synced value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync[0] <= i_sig;
            for (int k = 1; k < STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/i2c_codec_responder.sv
// Write-only I2C target for a codec control port: accepts
// START, address byte, two data bytes, and emits one register write
// (7-bit register address, 9-bit data) per completed transfer.
module i2c_codec_responder
    import i2c_codec_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = CODEC_DEV_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_sclk,
    input  logic       i2c_sdat_in,
    output logic       i2c_sdat_oe,
    output logic       reg_wr_valid,
    output logic [6:0] reg_addr,
    output logic [8:0] reg_data,
    output logic       busy
);

    logic       w_sclLevel;
    logic       w_sclRise;
    logic       w_sclFall;
    logic       w_sdaLevel;
    logic       w_sdaRise;
    logic       w_sdaFall;
    logic       w_start;
    logic       w_stop;
    logic       w_lastBit;
    logic [7:0] w_nextByte;

    state_t     r_state;
    logic [2:0] r_bitCnt;
    logic [7:0] r_shift;
    logic [7:0] r_byte1;
    logic       r_oe;
    logic       r_wrValid;
    logic [6:0] r_addr;
    logic [8:0] r_data;
    logic       r_busy;

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sclSync (
        .clk     (clk),
        .reset   (reset),
        .i_sig   (i2c_sclk),
        .o_level (w_sclLevel),
        .o_rise  (w_sclRise),
        .o_fall  (w_sclFall)
    );

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sdaSync (
        .clk     (clk),
        .reset   (reset),
        .i_sig   (i2c_sdat_in),
        .o_level (w_sdaLevel),
        .o_rise  (w_sdaRise),
        .o_fall  (w_sdaFall)
    );

    // SDA moving while SCL is high is a bus condition, never a data bit
    assign w_start    = w_sdaFall & w_sclLevel;
    assign w_stop     = w_sdaRise & w_sclLevel;
    assign w_lastBit  = (r_bitCnt == LAST_BIT);
    assign w_nextByte = {r_shift[6:0], w_sdaLevel};

    // Protocol FSM: START/STOP override every state; otherwise shift bits on
    // SCL rise and drive ACK from the falling edge after bit 8 to the next one.
    // Byte 2 stays in r_shift through ACK2, so it is read from there at commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_bitCnt  <= 3'd0;
            r_shift   <= 8'd0;
            r_byte1   <= 8'd0;
            r_oe      <= 1'b0;
            r_wrValid <= 1'b0;
            r_addr    <= 7'd0;
            r_data    <= 9'd0;
            r_busy    <= 1'b0;
        end else begin
            r_wrValid <= 1'b0;
            if (w_start) begin
                r_state  <= ST_ADDR;
                r_bitCnt <= 3'd0;
                r_oe     <= 1'b0;
                r_busy   <= 1'b0;
            end else if (w_stop) begin
                r_state  <= ST_IDLE;
                r_bitCnt <= 3'd0;
                r_oe     <= 1'b0;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    ST_ADDR: begin
                        if (w_sclRise) begin
                            r_shift  <= w_nextByte;
                            r_bitCnt <= r_bitCnt + 3'd1;
                            if (w_lastBit) begin
                                if (isWriteTo(w_nextByte, DEV_ADDR)) begin
                                    r_state <= ST_ADDR_ACK;
                                    r_busy  <= 1'b1;
                                end else begin
                                    r_state <= ST_IGNORE;
                                end
                            end
                        end
                    end
                    ST_BYTE1: begin
                        if (w_sclRise) begin
                            r_shift  <= w_nextByte;
                            r_bitCnt <= r_bitCnt + 3'd1;
                            if (w_lastBit) begin
                                r_byte1 <= w_nextByte;
                                r_state <= ST_ACK1;
                            end
                        end
                    end
                    ST_BYTE2: begin
                        if (w_sclRise) begin
                            r_shift  <= w_nextByte;
                            r_bitCnt <= r_bitCnt + 3'd1;
                            if (w_lastBit) begin
                                r_state <= ST_ACK2;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (w_sclFall) begin
                            if (!r_oe) begin
                                r_oe <= 1'b1;
                            end else begin
                                r_oe     <= 1'b0;
                                r_bitCnt <= 3'd0;
                                r_state  <= ST_BYTE1;
                            end
                        end
                    end
                    ST_ACK1: begin
                        if (w_sclFall) begin
                            if (!r_oe) begin
                                r_oe <= 1'b1;
                            end else begin
                                r_oe     <= 1'b0;
                                r_bitCnt <= 3'd0;
                                r_state  <= ST_BYTE2;
                            end
                        end
                    end
                    ST_ACK2: begin
                        if (w_sclFall) begin
                            if (!r_oe) begin
                                r_oe <= 1'b1;
                            end else begin
                                r_oe      <= 1'b0;
                                r_bitCnt  <= 3'd0;
                                r_state   <= ST_IGNORE;
                                r_busy    <= 1'b0;
                                r_wrValid <= 1'b1;
                                r_addr    <= r_byte1[7:1];
                                r_data    <= {r_byte1[0], r_shift};
                            end
                        end
                    end
                    ST_IDLE, ST_IGNORE: begin
                        r_oe   <= 1'b0;
                        r_busy <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_oe    <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign i2c_sdat_oe  = r_oe;
    assign reg_wr_valid = r_wrValid;
    assign reg_addr     = r_addr;
    assign reg_data     = r_data;
    assign busy         = r_busy;

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Bench for the codec I2C responder: an I2C initiator drives directed
// transactions, a transaction-level model predicts ACKs, busy and register
// writes, and a per-cycle monitor compares the DUT against that model.
module tb_i2c_codec_responder;

    localparam int         Q   = 4;
    localparam logic [6:0] DEV = 7'h1A;

    logic       clk = 1'b0;
    logic       reset;
    logic       i2c_sclk;
    logic       tbSda;
    logic       i2c_sdat_in;
    logic       i2c_sdat_oe;
    logic       reg_wr_valid;
    logic [6:0] reg_addr;
    logic [8:0] reg_data;
    logic       busy;

    int         checks = 0;
    int         errors = 0;
    int         pulseCount = 0;
    int         txnIdx = 0;
    logic       txnMatched = 1'b0;
    logic [7:0] txnByte1 = 8'h00;
    logic       allowOe = 1'b0;
    logic [6:0] heldAddr = 7'h00;
    logic [8:0] heldData = 9'h000;
    logic [6:0] expAddrQ [$];
    logic [8:0] expDataQ [$];

    // Open-drain bus: the line is low if either side pulls it low
    assign i2c_sdat_in = tbSda & ~i2c_sdat_oe;

    i2c_codec_responder #(.DEV_ADDR(DEV), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .i2c_sclk     (i2c_sclk),
        .i2c_sdat_in  (i2c_sdat_in),
        .i2c_sdat_oe  (i2c_sdat_oe),
        .reg_wr_valid (reg_wr_valid),
        .reg_addr     (reg_addr),
        .reg_data     (reg_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic waitQ();
        repeat (Q) @(negedge clk);
    endtask

    // START from idle or repeated START from SCL low
    task automatic i2cStart();
        tbSda = 1'b1;
        waitQ();
        i2c_sclk = 1'b1;
        waitQ();
        tbSda = 1'b0;
        waitQ();
        i2c_sclk = 1'b0;
        waitQ();
        txnIdx     = 0;
        txnMatched = 1'b0;
    endtask

    task automatic i2cStop();
        tbSda = 1'b0;
        waitQ();
        i2c_sclk = 1'b1;
        waitQ();
        tbSda = 1'b1;
        waitQ();
        waitQ();
        checkOutput("busyAfterStop", busy, 0);
    endtask

    // Eight data clocks; the ACK window opens at the falling edge ending bit 8
    task automatic sendBits(input logic [7:0] value, input logic ackWindow);
        for (int i = 7; i >= 0; i--) begin
            tbSda = value[i];
            waitQ();
            i2c_sclk = 1'b1;
            waitQ();
            waitQ();
            i2c_sclk = 1'b0;
            if (i == 0) allowOe = ackWindow;
            waitQ();
        end
    endtask

    // One byte plus its ACK clock, with the expectations taken from the protocol rules
    task automatic sendByte(input logic [7:0] value);
        logic ackExp;
        logic ackSeen;
        if (txnIdx == 0) txnMatched = (value[7:1] == DEV) && !value[0];
        ackExp = txnMatched && (txnIdx < 3);
        sendBits(value, ackExp);
        tbSda = 1'b1;
        waitQ();
        i2c_sclk = 1'b1;
        waitQ();
        ackSeen = ~i2c_sdat_in;
        waitQ();
        i2c_sclk = 1'b0;
        if (txnIdx == 1) txnByte1 = value;
        if (txnIdx == 2 && ackExp) begin
            expAddrQ.push_back(txnByte1[7:1]);
            expDataQ.push_back({txnByte1[0], value});
        end
        waitQ();
        allowOe = 1'b0;
        checkOutput($sformatf("ack%0d", txnIdx), ackSeen, ackExp);
        checkOutput($sformatf("busy%0d", txnIdx), busy, txnMatched && (txnIdx < 2));
        txnIdx++;
    endtask

    task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                                 input logic [7:0] b3, input int n, input logic withStop);
        logic [7:0] bytes [4];
        bytes[0] = b0;
        bytes[1] = b1;
        bytes[2] = b2;
        bytes[3] = b3;
        i2cStart();
        for (int i = 0; i < n; i++) sendByte(bytes[i]);
        if (withStop) begin
            i2cStop();
            repeat (4) @(negedge clk);
            checkOutput("pendingWrites", expAddrQ.size(), 0);
        end
    endtask

    // Per-cycle monitor: SDA only pulled inside an expected ACK window, each
    // write pulse matches the next predicted write, outputs held otherwise
    always @(negedge clk) begin
        checks++;
        if (i2c_sdat_oe && !allowOe) begin
            errors++;
            $display("[TB] FAIL oeWindow actual=1 expected=0 at %0t", $time);
        end
        checks++;
        if (reg_wr_valid) begin
            pulseCount++;
            if (expAddrQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpectedPulse actual=1 expected=0 at %0t", $time);
            end else begin
                if (reg_addr !== expAddrQ[0] || reg_data !== expDataQ[0]) begin
                    errors++;
                    $display("[TB] FAIL wrPayload actual=%0h/%0h expected=%0h/%0h", reg_addr, reg_data, expAddrQ[0], expDataQ[0]);
                end
                heldAddr = expAddrQ.pop_front();
                heldData = expDataQ.pop_front();
            end
        end else if (reg_addr !== heldAddr || reg_data !== heldData) begin
            errors++;
            $display("[TB] FAIL heldValue actual=%0h/%0h expected=%0h/%0h", reg_addr, reg_data, heldAddr, heldData);
        end
    end

    // Watchdog so a stuck bus sequence still ends the run
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        i2c_sclk = 1'b1;
        tbSda    = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rstOe", i2c_sdat_oe, 0);
        checkOutput("rstValid", reg_wr_valid, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstAddr", reg_addr, 0);
        checkOutput("rstData", reg_data, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] full write 34 0E 42");
        applyStimulus(8'h34, 8'h0E, 8'h42, 8'h00, 3, 1'b1);
        checkOutput("wr1Count", pulseCount, 1);
        checkOutput("wr1Addr", reg_addr, 7'h07);
        checkOutput("wr1Data", reg_data, 9'h042);

        $display("[TB] foreign address 36");
        applyStimulus(8'h36, 8'h0E, 8'h00, 8'h00, 2, 1'b1);
        checkOutput("foreignCount", pulseCount, 1);

        $display("[TB] read address 35");
        applyStimulus(8'h35, 8'h0E, 8'h00, 8'h00, 2, 1'b1);
        checkOutput("readCount", pulseCount, 1);

        $display("[TB] partial write 34 1E then STOP");
        applyStimulus(8'h34, 8'h1E, 8'h00, 8'h00, 2, 1'b1);
        checkOutput("partialCount", pulseCount, 1);
        checkOutput("partialAddrHeld", reg_addr, 7'h07);
        checkOutput("partialDataHeld", reg_data, 9'h042);

        $display("[TB] repeated START mid-write");
        applyStimulus(8'h34, 8'h0E, 8'h00, 8'h00, 2, 1'b0);
        applyStimulus(8'h34, 8'h0C, 8'h9F, 8'h00, 3, 1'b1);
        checkOutput("rsCount", pulseCount, 2);
        checkOutput("rsAddr", reg_addr, 7'h06);
        checkOutput("rsData", reg_data, 9'h09F);

        $display("[TB] third data byte");
        applyStimulus(8'h34, 8'h0B, 8'h5A, 8'hC3, 4, 1'b1);
        checkOutput("extraCount", pulseCount, 3);
        checkOutput("extraAddr", reg_addr, 7'h05);
        checkOutput("extraData", reg_data, 9'h15A);

        $display("[TB] reset during address ACK");
        i2cStart();
        sendBits(8'h34, 1'b1);
        for (int k = 0; k < 20 && !i2c_sdat_oe; k++) @(negedge clk);
        checkOutput("oeBeforeReset", i2c_sdat_oe, 1);
        @(posedge clk);
        #2;
        reset    = 1'b1;
        allowOe  = 1'b0;
        heldAddr = 7'h00;
        heldData = 9'h000;
        expAddrQ.delete();
        expDataQ.delete();
        #1;
        checkOutput("oeAsyncRelease", i2c_sdat_oe, 0);
        checkOutput("busyAsyncClear", busy, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        tbSda = 1'b1;
        waitQ();
        i2c_sclk = 1'b1;
        waitQ();
        checkOutput("noAckAfterReset", i2c_sdat_oe, 0);
        waitQ();
        i2c_sclk = 1'b0;
        waitQ();
        checkOutput("addrAfterReset", reg_addr, 7'h00);
        applyStimulus(8'h34, 8'h12, 8'h01, 8'h00, 3, 1'b1);
        checkOutput("postRstCount", pulseCount, 4);
        checkOutput("postRstAddr", reg_addr, 7'h09);
        checkOutput("postRstData", reg_data, 9'h001);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
